ram_arbiter: RTL and testbench

- Two-requester access controller for the 512x32 Mini-SRC main memory (`ram`).
- Shares the single memory port between the CPU datapath (MAR/MDR side) and a debug/program-loader port.
- Converts level-held requests into the setup → strobe → capture sequence the edge-triggered memory strobes require.
- Returns one-cycle acknowledges with latched read data.

---
 rtl/ram_arbiter.sv | 141 ++++++++++++++
 tb/tb_ram_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester access controller for the 512x32 Mini-SRC memory port.
// Define RAM_ARB_CPU_PRIORITY_EN for fixed CPU priority instead of round-robin.
module ram_arbiter #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 32,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_D,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_Q,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    CAPTURE,
    ACK
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(STROBE_CYCLES - 1);

  state_t     state;
  state_t     nstate;
  logic [1:0] cnt;
  logic       lat_we;
  logic       any_req;
  logic       grant;

  assign any_req = cpu_req | dbg_req;

  // grant: 0 = CPU, 1 = debug; only meaningful when any_req
`ifdef RAM_ARB_CPU_PRIORITY_EN
  always_comb begin
    grant = !cpu_req;
  end
`else
  always_comb begin
    grant = dbg_req;
    if (cpu_req && dbg_req)
      grant = !owner;
  end
`endif

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)
      state <= IDLE;
    else
      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (any_req) nstate = SETUP;
      SETUP:   nstate = STROBE;
      STROBE:  if (cnt == 2'd0) nstate = CAPTURE;
      CAPTURE: nstate = ACK;
      ACK:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    ram_read  = 1'b0;
    ram_write = 1'b0;
    cpu_ack   = 1'b0;
    dbg_ack   = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      STROBE: begin
        ram_write = lat_we;
        ram_read  = !lat_we;
      end
      ACK: begin
        cpu_ack = !owner;
        dbg_ack = owner;
      end
      default: ;
    endcase
  end

  // payload is frozen at grant so requester changes after IDLE are ignored
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      lat_we      <= 1'b0;
      ram_address <= '0;
      ram_D       <= '0;
      owner       <= 1'b1;
      cnt         <= 2'd0;
    end else begin
      if (state == IDLE && any_req) begin
        owner <= grant;
        if (grant) begin
          lat_we      <= dbg_we;
          ram_address <= dbg_addr;
          ram_D       <= dbg_wdata;
        end else begin
          lat_we      <= cpu_we;
          ram_address <= cpu_addr;
          ram_D       <= cpu_wdata;
        end
      end
      if (state == SETUP)
        cnt <= CNT_INIT;
      else if (state == STROBE && cnt != 2'd0)
        cnt <= cnt - 2'd1;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else if (state == CAPTURE && !lat_we) begin
      if (owner)
        dbg_rdata <= ram_Q;
      else
        cpu_rdata <= ram_Q;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: default strobe and 3-cycle strobe instances.
// Each instance talks to a small edge-strobed memory model.
module tb_ram_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic clear_n;
  logic preload;

  logic        cpu_req, cpu_we, cpu_ack;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [8:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic [8:0]  ram_address;
  logic [31:0] ram_D, ram_Q;
  logic        ram_read, ram_write, busy, owner;

  logic        cpu_req1, cpu_we1, cpu_ack1;
  logic [8:0]  cpu_addr1;
  logic [31:0] cpu_wdata1, cpu_rdata1;
  logic        dbg_req1, dbg_we1, dbg_ack1;
  logic [8:0]  dbg_addr1;
  logic [31:0] dbg_wdata1, dbg_rdata1;
  logic [8:0]  ram_address1;
  logic [31:0] ram_D1, ram_Q1;
  logic        ram_read1, ram_write1, busy1, owner1;

  logic [31:0] mem0 [0:511];
  logic [31:0] mem1 [0:511];

  int vecs = 0;
  int errs = 0;

  logic [15:0] rdv, wrv, cav, dav;
  logic [15:0] rdv1, wrv1, dav1;

  ram_arbiter u0 (
    .clock(clock), .clear_n(clear_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ram_address(ram_address), .ram_D(ram_D),
    .ram_read(ram_read), .ram_write(ram_write), .ram_Q(ram_Q),
    .busy(busy), .owner(owner)
  );

  ram_arbiter #(.STROBE_CYCLES(3)) u1 (
    .clock(clock), .clear_n(clear_n),
    .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1),
    .cpu_wdata(cpu_wdata1), .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1),
    .dbg_req(dbg_req1), .dbg_we(dbg_we1), .dbg_addr(dbg_addr1),
    .dbg_wdata(dbg_wdata1), .dbg_ack(dbg_ack1), .dbg_rdata(dbg_rdata1),
    .ram_address(ram_address1), .ram_D(ram_D1),
    .ram_read(ram_read1), .ram_write(ram_write1), .ram_Q(ram_Q1),
    .busy(busy1), .owner(owner1)
  );

  // memory: write and read happen on clock edges while the strobe is high
  always @(posedge clock) begin
    if (preload) begin
      mem0[9'h068] <= 32'h0000_0055;
      mem0[9'h052] <= 32'h1234_5678;
      mem0[9'h060] <= 32'hDEAD_BEEF;
    end else begin
      if (ram_write) mem0[ram_address] <= ram_D;
      if (ram_read)  ram_Q <= mem0[ram_address];
    end
    if (ram_write1) mem1[ram_address1] <= ram_D1;
    if (ram_read1)  ram_Q1 <= mem1[ram_address1];
  end

  task automatic tick0(input int c);
    @(negedge clock);
    rdv[c] = ram_read;
    wrv[c] = ram_write;
    cav[c] = cpu_ack;
    dav[c] = dbg_ack;
    @(posedge clock);
    #1;
  endtask

  task automatic tick1(input int c);
    @(negedge clock);
    rdv1[c] = ram_read1;
    wrv1[c] = ram_write1;
    dav1[c] = dbg_ack1;
    @(posedge clock);
    #1;
  endtask

  task automatic do0(input bit d, input bit we, input logic [8:0] a,
                     input logic [31:0] wd, input int n);
    rdv = '0; wrv = '0; cav = '0; dav = '0;
    if (d) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    end
    for (int c = 0; c < n; c++) tick0(c);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  task automatic do1(input bit we, input logic [8:0] a,
                     input logic [31:0] wd, input int n);
    rdv1 = '0; wrv1 = '0; dav1 = '0;
    dbg_req1 = 1'b1; dbg_we1 = we; dbg_addr1 = a; dbg_wdata1 = wd;
    for (int c = 0; c < n; c++) tick1(c);
    dbg_req1 = 1'b0;
  endtask

  task automatic tie_run(output int ct, output int dt);
    rdv = '0; wrv = '0; cav = '0; dav = '0;
    ct = -1;
    dt = -1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h068;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h052;
    for (int c = 0; c < 14; c++) begin
      tick0(c);
      if (cav[c] && ct < 0) begin ct = c; cpu_req = 1'b0; end
      if (dav[c] && dt < 0) begin dt = c; dbg_req = 1'b0; end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  task automatic test_reset;
    clear_n = 1'b1;
    preload = 1'b1;
    #2 clear_n = 1'b0;
    #1;
    vecs++;
    if ({busy, ram_read, ram_write, cpu_ack, dbg_ack} !== 5'b0) begin
      errs++;
      $display("FAIL reset_ctl: got %b want 00000",
               {busy, ram_read, ram_write, cpu_ack, dbg_ack});
    end
    vecs++;
    if ({cpu_rdata, dbg_rdata} !== 64'h0) begin
      errs++;
      $display("FAIL reset_rdata: got %h want 0", {cpu_rdata, dbg_rdata});
    end
    vecs++;
    if ({ram_address, ram_D} !== 41'h0) begin
      errs++;
      $display("FAIL reset_addr_d: got %h want 0", {ram_address, ram_D});
    end
    vecs++;
    if (owner !== 1'b1) begin
      errs++;
      $display("FAIL reset_owner: got %b want 1", owner);
    end
    repeat (3) @(posedge clock);
    #1;
    preload = 1'b0;
    clear_n = 1'b1;
  endtask

  task automatic test_cpu_read;
    do0(1'b0, 1'b0, 9'h068, 32'h0, 5);
    vecs++;
    if (rdv[4:0] !== 5'b00100) begin
      errs++;
      $display("FAIL rd_strobe: got %b want 00100", rdv[4:0]);
    end
    vecs++;
    if ({cav[4:0], dav[4:0], wrv[4:0]} !== 15'b10000_00000_00000) begin
      errs++;
      $display("FAIL rd_acks: got %b want 100000000000000",
               {cav[4:0], dav[4:0], wrv[4:0]});
    end
    vecs++;
    if (cpu_rdata !== 32'h0000_0055) begin
      errs++;
      $display("FAIL rd_data: got %h want 00000055", cpu_rdata);
    end
  endtask

  task automatic test_write_dbg_read;
    do0(1'b0, 1'b1, 9'h068, 32'h0000_00BC, 5);
    vecs++;
    if ({wrv[4:0], rdv[4:0], cav[4:0]} !== 15'b00100_00000_10000) begin
      errs++;
      $display("FAIL wr_pulse: got %b want 001000000010000",
               {wrv[4:0], rdv[4:0], cav[4:0]});
    end
    do0(1'b1, 1'b0, 9'h068, 32'h0, 5);
    vecs++;
    if ({dav[4:0], cav[4:0]} !== 10'b10000_00000) begin
      errs++;
      $display("FAIL dbg_acks: got %b want 1000000000",
               {dav[4:0], cav[4:0]});
    end
    vecs++;
    if (dbg_rdata !== 32'h0000_00BC) begin
      errs++;
      $display("FAIL dbg_rdata: got %h want 000000bc", dbg_rdata);
    end
    vecs++;
    if (cpu_rdata !== 32'h0000_0055) begin
      errs++;
      $display("FAIL cpu_rdata_kept: got %h want 00000055", cpu_rdata);
    end
    vecs++;
    if (owner !== 1'b1) begin
      errs++;
      $display("FAIL owner_dbg: got %b want 1", owner);
    end
  endtask

  task automatic test_tie;
    int ct, dt;
    clear_n = 1'b0;
    @(posedge clock);
    #1 clear_n = 1'b1;
    tie_run(ct, dt);
    vecs++;
    if (ct !== 4 || dt !== 9) begin
      errs++;
      $display("FAIL tie1: got cpu %0d dbg %0d want cpu 4 dbg 9", ct, dt);
    end
    do0(1'b0, 1'b0, 9'h052, 32'h0, 5);
    tie_run(ct, dt);
    vecs++;
`ifdef RAM_ARB_CPU_PRIORITY_EN
    if (ct !== 4 || dt !== 9) begin
      errs++;
      $display("FAIL tie2: got cpu %0d dbg %0d want cpu 4 dbg 9", ct, dt);
    end
`else
    if (ct !== 9 || dt !== 4) begin
      errs++;
      $display("FAIL tie2: got cpu %0d dbg %0d want cpu 9 dbg 4", ct, dt);
    end
`endif
    vecs++;
    if (dbg_rdata !== 32'h1234_5678) begin
      errs++;
      $display("FAIL tie_dbg_data: got %h want 12345678", dbg_rdata);
    end
  endtask

  task automatic test_payload_latch;
    cav = '0; dav = '0; rdv = '0; wrv = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h052;
    tick0(0);
    cpu_addr = 9'h060;
    for (int c = 1; c < 5; c++) tick0(c);
    cpu_req = 1'b0;
    vecs++;
    if (cav[4:0] !== 5'b10000) begin
      errs++;
      $display("FAIL latch_ack: got %b want 10000", cav[4:0]);
    end
    vecs++;
    if (cpu_rdata !== 32'h1234_5678) begin
      errs++;
      $display("FAIL latch_data: got %h want 12345678", cpu_rdata);
    end
    tick0(0);
    tick0(1);
    vecs++;
    if ({busy, ram_address} !== {1'b0, 9'h052}) begin
      errs++;
      $display("FAIL latch_addr: got %h want 052", {busy, ram_address});
    end
  endtask

  task automatic test_reset_midop;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h068;
    tick0(0);
    tick0(1);
    vecs++;
    if (ram_read !== 1'b1) begin
      errs++;
      $display("FAIL midop_strobe: got %b want 1", ram_read);
    end
    #2 clear_n = 1'b0;
    #1;
    vecs++;
    if ({ram_read, ram_write, busy, cpu_ack, dbg_ack} !== 5'b0) begin
      errs++;
      $display("FAIL midop_ctl: got %b want 00000",
               {ram_read, ram_write, busy, cpu_ack, dbg_ack});
    end
    vecs++;
    if ({cpu_rdata, owner} !== {32'h0, 1'b1}) begin
      errs++;
      $display("FAIL midop_state: got %h want 1", {cpu_rdata, owner});
    end
    cpu_req = 1'b0;
    @(posedge clock);
    #1 clear_n = 1'b1;
    do0(1'b0, 1'b0, 9'h068, 32'h0, 5);
    vecs++;
    if ({cav[4:0], cpu_rdata} !== {5'b10000, 32'h0000_00BC}) begin
      errs++;
      $display("FAIL midop_reissue: got %h want 10000000bc",
               {cav[4:0], cpu_rdata});
    end
  endtask

  task automatic test_long_strobe;
    do1(1'b1, 9'h0F0, 32'h0000_FFFF, 7);
    vecs++;
    if ({wrv1[6:0], rdv1[6:0]} !== {7'b0011100, 7'b0}) begin
      errs++;
      $display("FAIL long_wr: got %b want 00111000000000",
               {wrv1[6:0], rdv1[6:0]});
    end
    vecs++;
    if (dav1[6:0] !== 7'b1000000) begin
      errs++;
      $display("FAIL long_ack: got %b want 1000000", dav1[6:0]);
    end
    do1(1'b0, 9'h0F0, 32'h0, 7);
    vecs++;
    if ({rdv1[6:0], dav1[6:0]} !== {7'b0011100, 7'b1000000}) begin
      errs++;
      $display("FAIL long_rd: got %b want 00111001000000",
               {rdv1[6:0], dav1[6:0]});
    end
    vecs++;
    if (dbg_rdata1 !== 32'h0000_FFFF) begin
      errs++;
      $display("FAIL long_data: got %h want 0000ffff", dbg_rdata1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    cpu_req1 = 1'b0; cpu_we1 = 1'b0; cpu_addr1 = '0; cpu_wdata1 = '0;
    dbg_req1 = 1'b0; dbg_we1 = 1'b0; dbg_addr1 = '0; dbg_wdata1 = '0;
    rdv = '0; wrv = '0; cav = '0; dav = '0;
    rdv1 = '0; wrv1 = '0; dav1 = '0;
    test_reset;
    test_cpu_read;
    test_write_dbg_read;
    test_tie;
    test_payload_latch;
    test_reset_midop;
    test_long_strobe;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
